// File: rtl/fp32_serial_seq.sv
// Sequencer for the bit-serial FP32 adder: steers the serial pin into the operand
// shift registers, waits out the adder latency, then serialises the sum MSB-first.
module fp32_serial_seq #(
  parameter int WIDTH   = 32,
  parameter int ADD_LAT = 2,
  parameter int CNT_W   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             ser_in_i,
  input  logic [WIDTH-1:0] res_in_i,
  output logic             lda_o,
  output logic             ldb_o,
  output logic             inp_a_o,
  output logic             inp_b_o,
  output logic             ser_out_o,
  output logic             ser_valid_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_WAIT,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] BitLast  = CNT_W'(WIDTH - 1);
  localparam logic [3:0]       WaitLast = 4'(ADD_LAT - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [3:0]         wait_cnt_q, wait_cnt_d;
  logic [WIDTH-1:0]   res_sr_q, res_sr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
      res_sr_q   <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      res_sr_q   <= res_sr_d;
    end
  end

  // Abort wins over every transition, including start and the result capture.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    wait_cnt_d = wait_cnt_q;
    res_sr_d   = res_sr_q;
    if (abort_i) begin
      state_d    = S_IDLE;
      bit_cnt_d  = '0;
      wait_cnt_d = '0;
      res_sr_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d   = S_LOAD_A;
            bit_cnt_d = '0;
          end
        end
        S_LOAD_A: begin
          if (bit_cnt_q == BitLast) begin
            state_d   = S_LOAD_B;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        S_LOAD_B: begin
          if (bit_cnt_q == BitLast) begin
            state_d    = S_WAIT;
            bit_cnt_d  = '0;
            wait_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (wait_cnt_q == WaitLast) begin
            state_d   = S_SHIFT;
            res_sr_d  = res_in_i;
            bit_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end
        S_SHIFT: begin
          res_sr_d = {res_sr_q[WIDTH-2:0], 1'b0};
          if (bit_cnt_q == BitLast) begin
            state_d   = S_DONE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Operand bits are gated so the A/B registers see 0 outside their load phase.
  always_comb begin
    lda_o       = (state_q == S_LOAD_A);
    ldb_o       = (state_q == S_LOAD_B);
    inp_a_o     = lda_o & ser_in_i;
    inp_b_o     = ldb_o & ser_in_i;
    ser_valid_o = (state_q == S_SHIFT);
    ser_out_o   = ser_valid_o & res_sr_q[WIDTH-1];
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_fp32_serial_seq.sv
// Bench for fp32_serial_seq: cycle-timeline model for the control outputs plus a
// queue of expected result bits popped whenever ser_valid is seen.
module tb_fp32_serial_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        serIn;
  logic        start0, abort0, start1, abort1;
  logic [31:0] resIn0, resIn1;
  logic [7:0]  o0, o1, obs;
  bit          useLat1;
  int          total = 0;
  int          bad = 0;
  logic        expQ[$];
  logic [31:0] shA, shB;

  always #5 clk = ~clk;

  // obs bit order: lda, ldb, inp_a, inp_b, ser_out, ser_valid, busy, done
  assign obs = useLat1 ? o1 : o0;

  fp32_serial_seq #(.WIDTH(32), .ADD_LAT(2), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start_i(start0), .abort_i(abort0),
    .ser_in_i(serIn), .res_in_i(resIn0),
    .lda_o(o0[7]), .ldb_o(o0[6]), .inp_a_o(o0[5]), .inp_b_o(o0[4]),
    .ser_out_o(o0[3]), .ser_valid_o(o0[2]), .busy_o(o0[1]), .done_o(o0[0])
  );

  fp32_serial_seq #(.WIDTH(32), .ADD_LAT(1), .CNT_W(6)) dut1 (
    .clk(clk), .reset(reset), .start_i(start1), .abort_i(abort1),
    .ser_in_i(serIn), .res_in_i(resIn1),
    .lda_o(o1[7]), .ldb_o(o1[6]), .inp_a_o(o1[5]), .inp_b_o(o1[4]),
    .ser_out_o(o1[3]), .ser_valid_o(o1[2]), .busy_o(o1[1]), .done_o(o1[0])
  );

  // Expected {lda, ldb, ser_valid, busy, done} in cycle k after the start cycle.
  function automatic logic [4:0] expFlags(int k, int lat);
    expFlags = {(k >= 1 && k <= 32), (k >= 33 && k <= 64),
                (k >= 65 + lat && k <= 96 + lat), (k >= 1 && k <= 97 + lat),
                (k == 97 + lat)};
  endfunction

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic pushResult(input logic [31:0] r);
    for (int i = 31; i >= 0; i--) expQ.push_back(r[i]);
  endtask

  // res_in holds the wrong value except in the cycle ending with the capture edge.
  task automatic driveCycle(input int k, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] r, input int lat, input bit st, input bit ab);
    if (k >= 1 && k <= 32)       serIn = a[5'(32 - k)];
    else if (k >= 33 && k <= 64) serIn = b[5'(64 - k)];
    else                         serIn = 1'($urandom_range(1, 0));
    if (useLat1) begin
      start1 = st; abort1 = ab; resIn1 = (k == 64 + lat) ? r : ~r;
    end else begin
      start0 = st; abort0 = ab; resIn0 = (k == 64 + lat) ? r : ~r;
    end
    #1;
  endtask

  task automatic test_reset();
    start0 = 0; abort0 = 0; start1 = 0; abort1 = 0;
    serIn = 0; resIn0 = '0; resIn1 = '0; useLat1 = 0;
    #1 reset = 1'b1;
    #6;
    total++;
    if (o0 !== 8'h00) begin bad++; $display("[TB] FAIL reset_outputs_lat2 got=%b want=00000000", o0); end
    total++;
    if (o1 !== 8'h00) begin bad++; $display("[TB] FAIL reset_outputs_lat1 got=%b want=00000000", o1); end
    advance();
    reset = 1'b0;
    advance();
  endtask

  // Nominal 1.0 + 2.0 with stray start pulses in cycles 10 and 70.
  task automatic test_nominal();
    logic [31:0] a = 32'h3F80_0000, b = 32'h4000_0000, r = 32'h4040_0000;
    logic [4:0]  e;
    logic        expBit;
    useLat1 = 0; shA = '0; shB = '0;
    pushResult(r);
    for (int k = 0; k <= 100; k++) begin
      driveCycle(k, a, b, r, 2, (k == 0 || k == 10 || k == 70), 1'b0);
      e = expFlags(k, 2);
      total++;
      if ({obs[7], obs[6], obs[2], obs[1], obs[0]} !== e) begin
        bad++; $display("[TB] FAIL nominal_flags k=%0d got=%b want=%b", k, {obs[7], obs[6], obs[2], obs[1], obs[0]}, e);
      end
      total++;
      if (obs[5:4] !== {e[4] & serIn, e[3] & serIn}) begin
        bad++; $display("[TB] FAIL nominal_passthru k=%0d got=%b want=%b", k, obs[5:4], {e[4] & serIn, e[3] & serIn});
      end
      if (e[4]) shA = {shA[30:0], obs[5]};
      if (e[3]) shB = {shB[30:0], obs[4]};
      if (obs[2]) begin
        total++;
        expBit = (expQ.size() == 0) ? 1'bx : expQ.pop_front();
        if (obs[3] !== expBit) begin bad++; $display("[TB] FAIL nominal_serout k=%0d got=%b want=%b", k, obs[3], expBit); end
      end
      advance();
    end
    total++;
    if (shA !== a) begin bad++; $display("[TB] FAIL nominal_opA got=%h want=%h", shA, a); end
    total++;
    if (shB !== b) begin bad++; $display("[TB] FAIL nominal_opB got=%h want=%h", shB, b); end
    total++;
    if (expQ.size() != 0) begin bad++; $display("[TB] FAIL nominal_leftover got=%0d want=0", expQ.size()); end
    expQ.delete();
  endtask

  // start held high: one done in cycle 99, IDLE in 100, new LOAD_A in 101.
  task automatic test_start_while_busy();
    logic [31:0] a = 32'h4120_0000, b = 32'hBF00_0000, r = 32'h4118_0000;
    logic [4:0]  e;
    logic        expBit;
    useLat1 = 0;
    pushResult(r);
    for (int k = 0; k <= 101; k++) begin
      driveCycle(k, a, b, r, 2, 1'b1, 1'b0);
      e = (k <= 100) ? expFlags(k, 2) : 5'b10010;
      total++;
      if ({obs[7], obs[6], obs[2], obs[1], obs[0]} !== e) begin
        bad++; $display("[TB] FAIL held_start_flags k=%0d got=%b want=%b", k, {obs[7], obs[6], obs[2], obs[1], obs[0]}, e);
      end
      if (obs[2]) begin
        total++;
        expBit = (expQ.size() == 0) ? 1'bx : expQ.pop_front();
        if (obs[3] !== expBit) begin bad++; $display("[TB] FAIL held_start_serout k=%0d got=%b want=%b", k, obs[3], expBit); end
      end
      advance();
    end
    driveCycle(102, a, b, r, 2, 1'b0, 1'b1);
    advance();
    driveCycle(103, a, b, r, 2, 1'b0, 1'b0);
    total++;
    if (obs !== 8'h00) begin bad++; $display("[TB] FAIL held_start_abort got=%b want=00000000", obs); end
    total++;
    if (expQ.size() != 0) begin bad++; $display("[TB] FAIL held_start_leftover got=%0d want=0", expQ.size()); end
    expQ.delete();
    advance();
  endtask

  // Abort in LOAD_B (cycle 40), idle through 49, restart in 50, done in 149.
  task automatic test_abort();
    logic [31:0] a = 32'h3F80_0000, b = 32'h4000_0000, r = 32'h4040_0000;
    logic [4:0]  e;
    logic        expBit;
    useLat1 = 0;
    for (int k = 0; k <= 49; k++) begin
      driveCycle(k, a, b, r, 2, (k == 0), (k == 40));
      e = (k <= 40) ? expFlags(k, 2) : 5'b00000;
      total++;
      if ({obs[7], obs[6], obs[2], obs[1], obs[0]} !== e) begin
        bad++; $display("[TB] FAIL abort_flags k=%0d got=%b want=%b", k, {obs[7], obs[6], obs[2], obs[1], obs[0]}, e);
      end
      advance();
    end
    pushResult(r);
    for (int k = 0; k <= 100; k++) begin
      driveCycle(k, a, b, r, 2, (k == 0), 1'b0);
      e = expFlags(k, 2);
      total++;
      if ({obs[7], obs[6], obs[2], obs[1], obs[0]} !== e) begin
        bad++; $display("[TB] FAIL abort_restart_flags cyc=%0d got=%b want=%b", k + 50, {obs[7], obs[6], obs[2], obs[1], obs[0]}, e);
      end
      if (obs[2]) begin
        total++;
        expBit = (expQ.size() == 0) ? 1'bx : expQ.pop_front();
        if (obs[3] !== expBit) begin bad++; $display("[TB] FAIL abort_restart_serout k=%0d got=%b want=%b", k, obs[3], expBit); end
      end
      advance();
    end
    total++;
    if (expQ.size() != 0) begin bad++; $display("[TB] FAIL abort_leftover got=%0d want=0", expQ.size()); end
    expQ.delete();
  endtask

  // Reset mid-cycle 80 while shifting, then a fresh -3 + -2 = -5 transaction.
  task automatic test_async_reset();
    logic [31:0] a = 32'h3F80_0000, b = 32'h4000_0000, r = 32'h4040_0000;
    logic [31:0] a2 = 32'hC040_0000, b2 = 32'hC000_0000, r2 = 32'hC0A0_0000;
    logic [4:0]  e;
    logic        expBit;
    useLat1 = 0;
    pushResult(r);
    for (int k = 0; k <= 80; k++) begin
      driveCycle(k, a, b, r, 2, (k == 0), 1'b0);
      e = expFlags(k, 2);
      total++;
      if ({obs[7], obs[6], obs[2], obs[1], obs[0]} !== e) begin
        bad++; $display("[TB] FAIL reset_run_flags k=%0d got=%b want=%b", k, {obs[7], obs[6], obs[2], obs[1], obs[0]}, e);
      end
      if (obs[2]) begin
        total++;
        expBit = (expQ.size() == 0) ? 1'bx : expQ.pop_front();
        if (obs[3] !== expBit) begin bad++; $display("[TB] FAIL reset_run_serout k=%0d got=%b want=%b", k, obs[3], expBit); end
      end
      if (k != 80) advance();
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (obs !== 8'h00) begin bad++; $display("[TB] FAIL reset_midshift got=%b want=00000000", obs); end
    expQ.delete();
    @(posedge clk);
    #3 reset = 1'b0;
    advance();
    pushResult(r2);
    for (int k = 0; k <= 100; k++) begin
      driveCycle(k, a2, b2, r2, 2, (k == 0), 1'b0);
      e = expFlags(k, 2);
      total++;
      if ({obs[7], obs[6], obs[2], obs[1], obs[0]} !== e) begin
        bad++; $display("[TB] FAIL post_reset_flags k=%0d got=%b want=%b", k, {obs[7], obs[6], obs[2], obs[1], obs[0]}, e);
      end
      if (obs[2]) begin
        total++;
        expBit = (expQ.size() == 0) ? 1'bx : expQ.pop_front();
        if (obs[3] !== expBit) begin bad++; $display("[TB] FAIL post_reset_serout k=%0d got=%b want=%b", k, obs[3], expBit); end
      end
      advance();
    end
    total++;
    if (expQ.size() != 0) begin bad++; $display("[TB] FAIL post_reset_leftover got=%0d want=0", expQ.size()); end
    expQ.delete();
  endtask

  // ADD_LAT=1 instance: all-ones and single-LSB results, done in cycle 98.
  task automatic test_latency1();
    logic [31:0] results[2] = '{32'hFFFF_FFFF, 32'h0000_0001};
    logic [31:0] a = 32'h7F7F_FFFF, b = 32'h0000_0001;
    logic [4:0]  e;
    logic        expBit;
    useLat1 = 1;
    foreach (results[n]) begin
      pushResult(results[n]);
      for (int k = 0; k <= 99; k++) begin
        driveCycle(k, a, b, results[n], 1, (k == 0), 1'b0);
        e = expFlags(k, 1);
        total++;
        if ({obs[7], obs[6], obs[2], obs[1], obs[0]} !== e) begin
          bad++; $display("[TB] FAIL lat1_flags run=%0d k=%0d got=%b want=%b", n, k, {obs[7], obs[6], obs[2], obs[1], obs[0]}, e);
        end
        if (obs[2]) begin
          total++;
          expBit = (expQ.size() == 0) ? 1'bx : expQ.pop_front();
          if (obs[3] !== expBit) begin bad++; $display("[TB] FAIL lat1_serout run=%0d k=%0d got=%b want=%b", n, k, obs[3], expBit); end
        end
        advance();
      end
      total++;
      if (expQ.size() != 0) begin bad++; $display("[TB] FAIL lat1_leftover run=%0d got=%0d want=0", n, expQ.size()); end
      expQ.delete();
    end
    useLat1 = 0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_start_while_busy();
    test_abort();
    test_async_reset();
    test_latency1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp32_serial_seq.md
Name: fp32_serial_seq

Overview:
- Sequencer for the bit-serial FP32 adder datapath.
- Steers one serial input pin into the operand-A and operand-B shift registers by driving their load-enables for exactly WIDTH cycles each.
- Waits a fixed adder latency, captures the parallel sum, and shifts it out MSB-first on one serial output pin.
- Sits between the chip-level serial pins and the operand registers / adder core.

Parameters:
- WIDTH, 32, operand/result width in bits; also the number of shift cycles per phase.
- ADD_LAT, 2, cycles from the last operand-B bit until res_in is valid; legal range 1..15.
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a transaction; sampled only in IDLE.
- abort  input  1  synchronous cancel; returns to IDLE from any state.
- ser_in  input  1  serial operand bit stream, MSB-first, A then B.
- res_in  input  WIDTH  parallel adder result.
- lda  output  1  shift enable for operand-A register.
- ldb  output  1  shift enable for operand-B register.
- inp_a  output  1  serial bit to operand-A register.
- inp_b  output  1  serial bit to operand-B register.
- ser_out  output  1  serial result bit, MSB-first.
- ser_valid  output  1  ser_out carries a valid result bit.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at transaction end.

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
- Reset values: state=IDLE, bit counter=0, wait counter=0, result shift register=0. All outputs 0.
- Reset mid-transaction: immediate return to IDLE. Partial operand shifts are not undone; the next transaction overwrites them fully.
- States and transitions:
  - IDLE: start=1 at a clock edge -> LOAD_A, bit counter cleared.
  - LOAD_A: lda=1, inp_a=ser_in (combinational pass-through). Counter increments each cycle; after WIDTH cycles -> LOAD_B, counter cleared.
  - LOAD_B: ldb=1, inp_b=ser_in. After WIDTH cycles -> WAIT, wait counter cleared.
  - WAIT: lasts ADD_LAT cycles. At the edge ending the last WAIT cycle, res_in is loaded into the result shift register -> SHIFT.
  - SHIFT: ser_valid=1, ser_out=result_sr[WIDTH-1]. Register shifts left with zero-fill each cycle. After WIDTH cycles -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- inp_a and inp_b are 0 whenever lda/ldb are 0. lda and ldb are never both 1.
- busy=1 in LOAD_A, LOAD_B, WAIT, SHIFT and DONE.
- Total latency from the start-sampling edge to the done cycle: 3*WIDTH + ADD_LAT cycles. The done cycle is cycle 3*WIDTH+ADD_LAT+1 after the start cycle.
- start while busy: ignored, not queued. start held high through DONE begins a new transaction the cycle after DONE (IDLE is still visited for one cycle).
- abort:
  - Takes priority over all transitions, including start in IDLE and the WAIT capture.
  - At the next edge: state=IDLE, counters cleared, result shift register cleared.
  - No done pulse is produced.
- Counters compare against WIDTH-1 and never wrap within a phase.
- res_in is sampled only at the single capture edge. Its value at any other time has no effect.

Test Plan:
- Nominal add (WIDTH=32, ADD_LAT=2): start in cycle 0; ser_in drives 0x3F800000 then 0x40000000 MSB-first; model res_in=0x40400000.
  - lda high cycles 1..32; ldb high cycles 33..64.
  - ser_valid high cycles 67..98, serialising 0x40400000 MSB-first.
  - done in cycle 99; busy high cycles 1..99.
- Pass-through check: every cycle, inp_a==ser_in while lda=1 and inp_a==0 otherwise; same rule for inp_b/ldb. Scoreboard shift registers end holding A=0x3F800000, B=0x40000000.
- Start while busy: pulse start in cycles 10 and 70.
  - No effect; a single done in cycle 99.
  - start held 1 continuously -> second LOAD_A begins cycle 101.
- Abort in LOAD_B (cycle 40): IDLE from cycle 41 with busy=0, ldb=0, no done pulse. A new start in cycle 50 completes normally with done in cycle 149.
- Async reset in SHIFT (asserted mid-cycle 80): ser_valid, busy and ser_out drop to 0 immediately. After deassertion, a fresh transaction with res_in=0xC0A00000 produces the correct 32-bit stream.
- Boundary data and latency (ADD_LAT=1): res_in=0xFFFFFFFF then 0x00000001 across two runs give exact bit streams. done in cycle 98.
